// File: rtl/fib_seq_ctrl_pkg.sv
// Shared definitions for the Fibonacci register-file sequencer: FSM encoding
// and default datapath/address widths used by the controller and its interface.
package fib_seq_ctrl_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_ADDR_W     = 5;
    localparam int DEF_LAST_REG   = 31;
    localparam int FIRST_CALC_REG = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_INIT0 = 3'd1,
        ST_INIT1 = 3'd2,
        ST_CALC  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/fib_seq_ctrl_if.sv
// Bundle between the Fibonacci sequencer (master) and the register file /
// host side (slave): start request, two read ports, one write port, status.
interface fib_seq_ctrl_if #(
    parameter int DATA_W = fib_seq_ctrl_pkg::DEF_DATA_W,
    parameter int ADDR_W = fib_seq_ctrl_pkg::DEF_ADDR_W
);
    logic              start;
    logic [DATA_W-1:0] rd_data_a;
    logic [DATA_W-1:0] rd_data_b;
    logic [ADDR_W-1:0] raddr_a;
    logic [ADDR_W-1:0] raddr_b;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic [DATA_W-1:0] result;
    logic              ovf;

    modport master (
        input  start, rd_data_a, rd_data_b,
        output raddr_a, raddr_b, we, waddr, wdata, busy, done, result, ovf
    );

    modport slave (
        output start, rd_data_a, rd_data_b,
        input  raddr_a, raddr_b, we, waddr, wdata, busy, done, result, ovf
    );

endinterface

// File: rtl/fib_seq_ctrl.sv
// Fills registers 1..LAST_REG of an external register file with a Fibonacci
// sequence seeded by INIT_A/INIT_B, reporting completion, last value and overflow.
module fib_seq_ctrl #(
    parameter int                DATA_W   = fib_seq_ctrl_pkg::DEF_DATA_W,
    parameter int                ADDR_W   = fib_seq_ctrl_pkg::DEF_ADDR_W,
    parameter int                LAST_REG = fib_seq_ctrl_pkg::DEF_LAST_REG,
    parameter logic [DATA_W-1:0] INIT_A   = DATA_W'(1),
    parameter logic [DATA_W-1:0] INIT_B   = DATA_W'(1)
) (
    input  logic           clk,
    input  logic           rst,
    fib_seq_ctrl_if.master bus
);
    import fib_seq_ctrl_pkg::*;

    localparam logic [ADDR_W-1:0] ONE_K   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] TWO_K   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] FIRST_K = ADDR_W'(FIRST_CALC_REG);
    localparam logic [ADDR_W-1:0] LAST_K  = ADDR_W'(LAST_REG);

    state_t            r_state;
    logic [ADDR_W-1:0] r_k;
    logic [ADDR_W-1:0] r_raddr_a;
    logic [ADDR_W-1:0] r_raddr_b;
    logic              r_we;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_init_data;
    logic              r_busy;
    logic              r_done;
    logic [DATA_W-1:0] r_result;
    logic              r_ovf;

    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_wdata;

    // The register file reads combinationally, so the CALC write data must be
    // formed in the same cycle the read addresses are presented.
    assign w_sum   = {1'b0, bus.rd_data_a} + {1'b0, bus.rd_data_b};
    assign w_wdata = (r_state == ST_CALC) ? w_sum[DATA_W-1:0] : r_init_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_k         <= '0;
            r_raddr_a   <= '0;
            r_raddr_b   <= '0;
            r_we        <= 1'b0;
            r_waddr     <= '0;
            r_init_data <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_ovf       <= 1'b0;
        end else begin
            if (r_we) begin
                r_result <= w_wdata;
            end

            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state     <= ST_INIT0;
                        r_we        <= 1'b1;
                        r_waddr     <= ONE_K;
                        r_init_data <= INIT_A;
                        r_busy      <= 1'b1;
                        r_ovf       <= 1'b0;
                    end
                end

                ST_INIT0: begin
                    r_state     <= ST_INIT1;
                    r_waddr     <= TWO_K;
                    r_init_data <= INIT_B;
                end

                // Outputs are set up one edge ahead, so CALC at k starts with
                // reads of k-2 / k-1 already on the address lines.
                ST_INIT1: begin
                    r_state     <= ST_CALC;
                    r_k         <= FIRST_K;
                    r_waddr     <= FIRST_K;
                    r_raddr_a   <= ONE_K;
                    r_raddr_b   <= TWO_K;
                    r_init_data <= '0;
                end

                ST_CALC: begin
                    if (w_sum[DATA_W]) begin
                        r_ovf <= 1'b1;
                    end
                    if (r_k == LAST_K) begin
                        r_state   <= ST_DONE;
                        r_we      <= 1'b0;
                        r_waddr   <= '0;
                        r_raddr_a <= '0;
                        r_raddr_b <= '0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end else begin
                        r_k       <= r_k + ONE_K;
                        r_waddr   <= r_k + ONE_K;
                        r_raddr_a <= r_k - ONE_K;
                        r_raddr_b <= r_k;
                    end
                end

                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_done  <= 1'b0;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_we    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.raddr_a = r_raddr_a;
    assign bus.raddr_b = r_raddr_b;
    assign bus.we      = r_we;
    assign bus.waddr   = r_waddr;
    assign bus.wdata   = w_wdata;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.result  = r_result;
    assign bus.ovf     = r_ovf;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
// Directed bench for fib_seq_ctrl: three parameterisations, each with a small
// behavioural register file, checked cycle by cycle against hand-derived values.
module tb_fib_seq_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    fib_seq_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus0 ();
    fib_seq_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus1 ();
    fib_seq_ctrl_if #(.DATA_W(32), .ADDR_W(5)) bus2 ();

    fib_seq_ctrl u_dut0 (.clk(clk), .rst(rst), .bus(bus0));
    fib_seq_ctrl #(.LAST_REG(3)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    fib_seq_ctrl #(.LAST_REG(3), .INIT_A(32'h8000_0000), .INIT_B(32'h8000_0000))
        u_dut2 (.clk(clk), .rst(rst), .bus(bus2));

    // Register files: write on the edge, combinational read
    logic [31:0] rf0 [0:31];
    logic [31:0] rf1 [0:31];
    logic [31:0] rf2 [0:31];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                rf0[i] <= '0;
                rf1[i] <= '0;
                rf2[i] <= '0;
            end
        end else begin
            if (bus0.we) rf0[bus0.waddr] <= bus0.wdata;
            if (bus1.we) rf1[bus1.waddr] <= bus1.wdata;
            if (bus2.we) rf2[bus2.waddr] <= bus2.wdata;
        end
    end

    assign bus0.rd_data_a = rf0[bus0.raddr_a];
    assign bus0.rd_data_b = rf0[bus0.raddr_b];
    assign bus1.rd_data_a = rf1[bus1.raddr_a];
    assign bus1.rd_data_b = rf1[bus1.raddr_b];
    assign bus2.rd_data_a = rf2[bus2.raddr_a];
    assign bus2.rd_data_b = rf2[bus2.raddr_b];

    // Observation mux selecting the instance under test
    int          o_sel = 0;
    logic        o_we, o_busy, o_done, o_ovf;
    logic [4:0]  o_waddr, o_raddr_a, o_raddr_b;
    logic [31:0] o_wdata, o_result;

    always_comb begin
        o_we = bus0.we; o_busy = bus0.busy; o_done = bus0.done; o_ovf = bus0.ovf;
        o_waddr = bus0.waddr; o_raddr_a = bus0.raddr_a; o_raddr_b = bus0.raddr_b;
        o_wdata = bus0.wdata; o_result = bus0.result;
        case (o_sel)
            1: begin
                o_we = bus1.we; o_busy = bus1.busy; o_done = bus1.done; o_ovf = bus1.ovf;
                o_waddr = bus1.waddr; o_raddr_a = bus1.raddr_a; o_raddr_b = bus1.raddr_b;
                o_wdata = bus1.wdata; o_result = bus1.result;
            end
            2: begin
                o_we = bus2.we; o_busy = bus2.busy; o_done = bus2.done; o_ovf = bus2.ovf;
                o_waddr = bus2.waddr; o_raddr_a = bus2.raddr_a; o_raddr_b = bus2.raddr_b;
                o_wdata = bus2.wdata; o_result = bus2.result;
            end
            default: ;
        endcase
    end

    // Capture buffers; index c = cycle number after the edge that sampled start
    logic        cap_we     [0:127];
    logic        cap_busy   [0:127];
    logic        cap_done   [0:127];
    logic        cap_ovf    [0:127];
    logic [4:0]  cap_waddr  [0:127];
    logic [4:0]  cap_raddr_a[0:127];
    logic [4:0]  cap_raddr_b[0:127];
    logic [31:0] cap_wdata  [0:127];
    logic [31:0] cap_result [0:127];

    logic [31:0] fib [0:31];

    task automatic init_model();
        fib[0] = 32'd0;
        fib[1] = 32'd1;
        fib[2] = 32'd1;
        for (int i = 3; i < 32; i++) fib[i] = fib[i-1] + fib[i-2];
    endtask

    task automatic drive_start(input int sel, input logic v);
        case (sel)
            0:       bus0.start = v;
            1:       bus1.start = v;
            default: bus2.start = v;
        endcase
    endtask

    // Called at a negedge; pat[c] is the start level held during cycle c
    task automatic capture(input int sel, input int ncyc, input logic [127:0] pat);
        o_sel = sel;
        drive_start(sel, pat[0]);
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            cap_we[c] = o_we;       cap_busy[c] = o_busy;       cap_done[c] = o_done;
            cap_ovf[c] = o_ovf;     cap_waddr[c] = o_waddr;     cap_wdata[c] = o_wdata;
            cap_raddr_a[c] = o_raddr_a; cap_raddr_b[c] = o_raddr_b; cap_result[c] = o_result;
            drive_start(sel, pat[c]);
        end
        drive_start(sel, 1'b0);
    endtask

    task automatic do_reset();
        bus0.start = 1'b0; bus1.start = 1'b0; bus2.start = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; o_sel = 0;
        bus0.start = 1'b1; bus1.start = 1'b0; bus2.start = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (o_busy !== 1'b0)    begin n_err++; $display("FAIL rst_busy got=%b exp=0", o_busy); end
        n_vec++; if (o_done !== 1'b0)    begin n_err++; $display("FAIL rst_done got=%b exp=0", o_done); end
        n_vec++; if (o_we !== 1'b0)      begin n_err++; $display("FAIL rst_we got=%b exp=0", o_we); end
        n_vec++; if (o_result !== 32'd0) begin n_err++; $display("FAIL rst_result got=%0d exp=0", o_result); end
        n_vec++; if (o_ovf !== 1'b0)     begin n_err++; $display("FAIL rst_ovf got=%b exp=0", o_ovf); end
        n_vec++; if (o_waddr !== 5'd0)   begin n_err++; $display("FAIL rst_waddr got=%0d exp=0", o_waddr); end
        n_vec++; if (o_wdata !== 32'd0)  begin n_err++; $display("FAIL rst_wdata got=%0d exp=0", o_wdata); end
        n_vec++; if (o_raddr_a !== 5'd0) begin n_err++; $display("FAIL rst_raddr_a got=%0d exp=0", o_raddr_a); end
        n_vec++; if (bus1.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy_inst1 got=%b exp=0", bus1.busy); end
        n_vec++; if (bus2.ovf !== 1'b0)  begin n_err++; $display("FAIL rst_ovf_inst2 got=%b exp=0", bus2.ovf); end
        bus0.start = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL rst_start_ignored busy got=%b exp=0", o_busy); end
        $display("reset: outputs cleared, start during reset ignored");
    endtask

    task automatic test_default_run();
        int nw;
        nw = 0;
        capture(0, 34, 128'h1);
        for (int c = 1; c <= 34; c++) begin
            logic ew;
            ew = (c <= 31);
            if (cap_we[c] === 1'b1) nw++;
            n_vec++; if (cap_we[c] !== ew)          begin n_err++; $display("FAIL run31_we c=%0d got=%b exp=%b", c, cap_we[c], ew); end
            n_vec++; if (cap_busy[c] !== ew)        begin n_err++; $display("FAIL run31_busy c=%0d got=%b exp=%b", c, cap_busy[c], ew); end
            n_vec++; if (cap_done[c] !== (c == 32)) begin n_err++; $display("FAIL run31_done c=%0d got=%b exp=%b", c, cap_done[c], (c == 32)); end
            n_vec++; if (cap_waddr[c] !== (ew ? 5'(c) : 5'd0)) begin n_err++; $display("FAIL run31_waddr c=%0d got=%0d exp=%0d", c, cap_waddr[c], (ew ? c : 0)); end
            n_vec++; if (cap_wdata[c] !== (ew ? fib[c] : 32'd0)) begin n_err++; $display("FAIL run31_wdata c=%0d got=%0d exp=%0d", c, cap_wdata[c], (ew ? fib[c] : 32'd0)); end
            if (c >= 3 && c <= 31) begin
                n_vec++; if (cap_raddr_a[c] !== 5'(c - 2)) begin n_err++; $display("FAIL run31_raddr_a c=%0d got=%0d exp=%0d", c, cap_raddr_a[c], c - 2); end
                n_vec++; if (cap_raddr_b[c] !== 5'(c - 1)) begin n_err++; $display("FAIL run31_raddr_b c=%0d got=%0d exp=%0d", c, cap_raddr_b[c], c - 1); end
            end
        end
        n_vec++; if (nw != 31)                     begin n_err++; $display("FAIL run31_writes got=%0d exp=31", nw); end
        n_vec++; if (cap_result[32] !== 32'd1346269) begin n_err++; $display("FAIL run31_result got=%0d exp=1346269", cap_result[32]); end
        n_vec++; if (rf0[31] !== 32'd1346269)      begin n_err++; $display("FAIL run31_r31 got=%0d exp=1346269", rf0[31]); end
        n_vec++; if (cap_ovf[34] !== 1'b0)         begin n_err++; $display("FAIL run31_ovf got=%b exp=0", cap_ovf[34]); end
        $display("default run: %0d writes, result=%0d", nw, cap_result[32]);
    endtask

    task automatic test_last_reg3();
        capture(1, 6, 128'h1);
        n_vec++; if (cap_waddr[1] !== 5'd1 || cap_wdata[1] !== 32'd1) begin n_err++; $display("FAIL l3_w1 got=r%0d:%0d exp=r1:1", cap_waddr[1], cap_wdata[1]); end
        n_vec++; if (cap_waddr[2] !== 5'd2 || cap_wdata[2] !== 32'd1) begin n_err++; $display("FAIL l3_w2 got=r%0d:%0d exp=r2:1", cap_waddr[2], cap_wdata[2]); end
        n_vec++; if (cap_waddr[3] !== 5'd3 || cap_wdata[3] !== 32'd2) begin n_err++; $display("FAIL l3_w3 got=r%0d:%0d exp=r3:2", cap_waddr[3], cap_wdata[3]); end
        for (int c = 1; c <= 6; c++) begin
            n_vec++; if (cap_we[c] !== (c <= 3))  begin n_err++; $display("FAIL l3_we c=%0d got=%b exp=%b", c, cap_we[c], (c <= 3)); end
            n_vec++; if (cap_done[c] !== (c == 4)) begin n_err++; $display("FAIL l3_done c=%0d got=%b exp=%b", c, cap_done[c], (c == 4)); end
        end
        n_vec++; if (cap_result[4] !== 32'd2) begin n_err++; $display("FAIL l3_result got=%0d exp=2", cap_result[4]); end
        n_vec++; if (rf1[3] !== 32'd2)        begin n_err++; $display("FAIL l3_r3 got=%0d exp=2", rf1[3]); end
        $display("LAST_REG=3 run: r1=%0d r2=%0d r3=%0d result=%0d", rf1[1], rf1[2], rf1[3], cap_result[4]);
    endtask

    task automatic test_start_ignored();
        int nw;
        nw = 0;
        // start raised in INIT1, CALC and DONE as well as the initial request
        capture(1, 8, 128'h1D);
        n_vec++; if (cap_result[1] !== 32'd2) begin n_err++; $display("FAIL ign_result_retained got=%0d exp=2", cap_result[1]); end
        for (int c = 1; c <= 8; c++) begin
            if (cap_we[c] === 1'b1) nw++;
            n_vec++; if (cap_busy[c] !== (c <= 3)) begin n_err++; $display("FAIL ign_busy c=%0d got=%b exp=%b", c, cap_busy[c], (c <= 3)); end
            n_vec++; if (cap_done[c] !== (c == 4)) begin n_err++; $display("FAIL ign_done c=%0d got=%b exp=%b", c, cap_done[c], (c == 4)); end
        end
        n_vec++; if (nw != 3) begin n_err++; $display("FAIL ign_writes got=%0d exp=3", nw); end
        $display("start while busy/done: %0d writes, no restart", nw);
    endtask

    task automatic test_overflow();
        capture(2, 6, 128'h1);
        n_vec++; if (cap_result[2] !== 32'h8000_0000) begin n_err++; $display("FAIL ovf_result_r1 got=%h exp=80000000", cap_result[2]); end
        n_vec++; if (cap_wdata[3] !== 32'd0)          begin n_err++; $display("FAIL ovf_wdata_r3 got=%h exp=0", cap_wdata[3]); end
        n_vec++; if (cap_ovf[3] !== 1'b0)             begin n_err++; $display("FAIL ovf_early got=%b exp=0", cap_ovf[3]); end
        n_vec++; if (cap_ovf[4] !== 1'b1)             begin n_err++; $display("FAIL ovf_set got=%b exp=1", cap_ovf[4]); end
        n_vec++; if (cap_result[4] !== 32'd0)         begin n_err++; $display("FAIL ovf_result got=%h exp=0", cap_result[4]); end
        n_vec++; if (rf2[3] !== 32'd0)                begin n_err++; $display("FAIL ovf_r3 got=%h exp=0", rf2[3]); end
        n_vec++; if (cap_ovf[6] !== 1'b1)             begin n_err++; $display("FAIL ovf_sticky got=%b exp=1", cap_ovf[6]); end
        $display("overflow run: r3=%h ovf=%b", rf2[3], cap_ovf[6]);
    endtask

    task automatic test_ovf_clear();
        capture(2, 5, 128'h1);
        n_vec++; if (cap_ovf[1] !== 1'b0)  begin n_err++; $display("FAIL ovfclr_on_start got=%b exp=0", cap_ovf[1]); end
        n_vec++; if (cap_busy[1] !== 1'b1) begin n_err++; $display("FAIL ovfclr_busy got=%b exp=1", cap_busy[1]); end
        n_vec++; if (cap_ovf[4] !== 1'b1)  begin n_err++; $display("FAIL ovfclr_reset got=%b exp=1", cap_ovf[4]); end
        $display("new start clears ovf: ovf after start edge=%b", cap_ovf[1]);
    endtask

    task automatic test_back_to_back();
        int nw, nd;
        int dc [$];
        nw = 0; nd = 0;
        capture(0, 100, '1);
        for (int c = 1; c <= 100; c++) begin
            int p;
            p = (c - 1) % 33 + 1;
            if (cap_we[c] === 1'b1) nw++;
            if (cap_done[c] === 1'b1) begin nd++; dc.push_back(c); end
            n_vec++; if (cap_we[c] !== (p <= 31)) begin n_err++; $display("FAIL b2b_we c=%0d got=%b exp=%b", c, cap_we[c], (p <= 31)); end
            if (p <= 31) begin
                n_vec++; if (cap_waddr[c] !== 5'(p) || cap_wdata[c] !== fib[p]) begin n_err++; $display("FAIL b2b_write c=%0d got=r%0d:%0d exp=r%0d:%0d", c, cap_waddr[c], cap_wdata[c], p, fib[p]); end
            end
        end
        n_vec++; if (nd != 3)  begin n_err++; $display("FAIL b2b_done_count got=%0d exp=3", nd); end
        n_vec++; if (nw != 94) begin n_err++; $display("FAIL b2b_writes got=%0d exp=94", nw); end
        if (nd == 3) begin
            n_vec++; if (dc[0] != 32)         begin n_err++; $display("FAIL b2b_first_done got=%0d exp=32", dc[0]); end
            n_vec++; if (dc[1] - dc[0] != 33) begin n_err++; $display("FAIL b2b_gap1 got=%0d exp=33", dc[1] - dc[0]); end
            n_vec++; if (dc[2] - dc[1] != 33) begin n_err++; $display("FAIL b2b_gap2 got=%0d exp=33", dc[2] - dc[1]); end
        end
        $display("back-to-back: %0d done pulses, %0d writes over 100 cycles", nd, nw);
        do_reset();
    endtask

    task automatic test_reset_mid_calc();
        int nd;
        nd = 0;
        o_sel = 0;
        bus0.start = 1'b1;
        @(negedge clk);
        bus0.start = 1'b0;
        repeat (9) @(negedge clk);
        n_vec++; if (o_waddr !== 5'd10 || o_busy !== 1'b1) begin n_err++; $display("FAIL mid_k10 got=k%0d busy=%b exp=k10 busy=1", o_waddr, o_busy); end
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (o_we !== 1'b0)      begin n_err++; $display("FAIL mid_rst_we got=%b exp=0", o_we); end
        n_vec++; if (o_busy !== 1'b0)    begin n_err++; $display("FAIL mid_rst_busy got=%b exp=0", o_busy); end
        n_vec++; if (o_result !== 32'd0) begin n_err++; $display("FAIL mid_rst_result got=%0d exp=0", o_result); end
        rst = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (o_done === 1'b1) nd++;
        end
        n_vec++; if (nd != 0) begin n_err++; $display("FAIL mid_no_done got=%0d exp=0", nd); end
        capture(0, 33, 128'h1);
        n_vec++; if (cap_done[32] !== 1'b1)           begin n_err++; $display("FAIL mid_fresh_done got=%b exp=1", cap_done[32]); end
        n_vec++; if (cap_result[32] !== 32'd1346269)  begin n_err++; $display("FAIL mid_fresh_result got=%0d exp=1346269", cap_result[32]); end
        $display("reset mid-CALC: aborted at k=10, fresh run result=%0d", cap_result[32]);
    endtask

    initial begin
        init_model();
        test_reset();
        test_default_run();
        test_last_reg3();
        test_start_ignored();
        test_overflow();
        test_ovf_clear();
        test_back_to_back();
        test_reset_mid_calc();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fib_seq_ctrl.md
FIB_SEQ_CTRL -- requirements
Module: fib_seq_ctrl

Interface
REQ-001 Parameter DATA_W, 32, datapath width.
REQ-002 Parameter ADDR_W, 5, register-file address width.
REQ-003 Parameter LAST_REG, 31, final register written; legal range 3..2^ADDR_W-1.
REQ-004 Parameter INIT_A, 1, value written to r1.
REQ-005 Parameter INIT_B, 1, value written to r2.
REQ-006 clk  in  1  single clock; all state changes on its rising edge.
REQ-007 rst  in  1  synchronous active-high reset, sampled on the rising edge of clk.
REQ-008 start  in  1  request one sequence run; level sampled, acted on only in IDLE.
REQ-009 rd_data_a  in  DATA_W  register-file read port A data (combinational read of raddr_a).
REQ-010 rd_data_b  in  DATA_W  register-file read port B data (combinational read of raddr_b).
REQ-011 raddr_a  out  ADDR_W  read address A.
REQ-012 raddr_b  out  ADDR_W  read address B.
REQ-013 we  out  1  register-file write enable.
REQ-014 waddr  out  ADDR_W  write address.
REQ-015 wdata  out  DATA_W  write data.
REQ-016 busy  out  1  high in INIT0, INIT1, CALC.
REQ-017 done  out  1  one-cycle pulse when the run completes.
REQ-018 result  out  DATA_W  last value written; feeds the top-level result port.
REQ-019 ovf  out  1  sticky: any CALC addition produced a carry out of DATA_W bits.

Function
REQ-020 FSM states SHALL be IDLE, INIT0, INIT1, CALC, DONE; state and step counter k registered.
REQ-021 IDLE: start=1 -> INIT0 next cycle; ovf cleared on that same edge; result retained.
REQ-022 INIT0 (one cycle): we=1, waddr=1, wdata=INIT_A -> INIT1.
REQ-023 INIT1 (one cycle): we=1, waddr=2, wdata=INIT_B; k loaded with 3 -> CALC.
REQ-024 CALC: raddr_a=k-2, raddr_b=k-1, wdata=(rd_data_a+rd_data_b) mod 2^DATA_W, we=1, waddr=k.
REQ-025 CALC: if k==LAST_REG -> DONE, else k<=k+1 and remain in CALC.
REQ-026 CALC occupies exactly LAST_REG-2 cycles; done SHALL assert LAST_REG+1 cycles after the edge sampling start.
REQ-027 DONE (one cycle): done=1, we=0 -> IDLE; start in DONE ignored.
REQ-028 we SHALL be 0 in IDLE and DONE; raddr_*, waddr, wdata are don't-care when we=0 but SHALL be driven to 0.
REQ-029 result SHALL load wdata on every edge where we=1.
REQ-030 ovf SHALL set on the CALC edge where the DATA_W+1-bit sum has MSB=1; cleared only by rst or new start.
REQ-031 start while busy or in DONE SHALL have no effect (no restart, no queuing).
REQ-032 Register-file write-before-read: value written at edge n SHALL be readable by CALC in cycle n+1 (no bypass inside this block).

Reset
REQ-033 rst=1 SHALL force IDLE, k=0, we=0, busy=0, done=0, result=0, ovf=0 at the next edge, overriding any state including mid-CALC.
REQ-034 start asserted in the same cycle as rst SHALL be ignored.

Structure
REQ-035 State encoding (IDLE..DONE) and default widths SHALL live in the shared lab package, reused by the top-level.
REQ-036 No sub-module; adder inline; instantiated in top alongside the existing register file, result wired to top.result.

Verification
REQ-037 Defaults, start pulse 1 cycle -> 31 writes, done 32 cycles after start edge, result=1346269, r31=1346269, ovf=0.
REQ-038 LAST_REG=3 -> writes r1=1, r2=1, r3=2; done 4 cycles after start; result=2.
REQ-039 INIT_A=INIT_B=32'h8000_0000, LAST_REG=3 -> r3=0, result=0, ovf=1; second run with defaults clears ovf to 0.
REQ-040 start held high continuously -> back-to-back runs, each done separated by 33 cycles, no extra writes during busy.
REQ-041 rst asserted during CALC at k=10 -> next edge we=0, busy=0, result=0; no done pulse; fresh start completes normally.
